// File: rtl/wca_rbus_pkg.sv
// rtl/wca_rbus_pkg.sv - WCA register bus field positions and shared helpers
// Purpose: bit positions inside the 12-bit rbusCtrl word and the bus data
//          width. Also holds a helper for sizing byte-select counters.
// Ports:   none (package)
package wca_rbus_pkg;

   localparam int RBUS_CTRL_W   = 12;
   localparam int RBUS_ADDR_MSB = 11;
   localparam int RBUS_ADDR_LSB = 4;
   localparam int RBUS_RD_BIT   = 3;
   localparam int RBUS_WR_BIT   = 2;
   localparam int RBUS_STB_BIT  = 1;
   localparam int RBUS_CLK_BIT  = 0;
   localparam int RBUS_DATA_W   = 8;

   // A 1-byte word still needs a 1-bit counter so the select logic stays legal.
   function automatic int sel_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/wca_read_multi_reg_if.sv
// rtl/wca_read_multi_reg_if.sv - capture-side handshake between fabric and wca_read_multi_reg
// Purpose: groups the word-capture handshake.
// Signals: in_valid - capture request
//          in       - 8*NUM_BYTES word to capture
//          in_ready - FIFO not full
// Modports: master (fabric producer), slave (register block)
interface wca_read_multi_reg_if #(
   parameter int NUM_BYTES = 4
);
   logic                   in_valid;
   logic [8*NUM_BYTES-1:0] in;
   logic                   in_ready;

   modport master (output in_valid, output in, input in_ready);
   modport slave  (input in_valid, input in, output in_ready);
endinterface

// File: rtl/wca_sync_fifo.sv
// rtl/wca_sync_fifo.sv - single-clock FIFO with occupancy count
// Purpose: word storage for the buffered read register.
// Ports:   clock, reset     - clock, synchronous active-high reset
//          push, push_data  - write request/data (ignored when full)
//          pop              - remove head (ignored when empty)
//          head             - head entry, all zeros when empty
//          full, empty      - occupancy flags
//          level            - stored entry count, 0..DEPTH
module wca_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign level   = level_q;
   assign head    = empty ? '0 : mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push_ok && !pop_ok) begin
         level_d = level_q + 1'b1;
      end else if (!push_ok && pop_ok) begin
         level_d = level_q - 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   // Storage is not reset; contents are only visible through level/empty.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

endmodule

// File: rtl/wca_read_multi_reg.sv
// rtl/wca_read_multi_reg.sv - buffered multi-byte read-only register on the 8-bit WCA bus
// Purpose: captures wide status words into a FIFO and serves each as
//          NUM_BYTES sequential byte reads, LSB first, popping after the last.
// Option:  WCA_RDREG_STATUS_EN adds a status byte at MY_ADDR+1:
//          {overflow, 2'b00, level}; a strobed status read clears overflow.
// Ports:   clock, reset - clock, synchronous active-high reset
//          cap          - capture handshake (slave): in_valid, in, in_ready
//          level        - stored word count
//          overflow     - sticky, a capture was dropped
//          rbusCtrl     - {addr[7:0], readEnable, writeEnable, dataStrobe, clkbus}
//          rbusData     - tri-state bus data
module wca_read_multi_reg
   import wca_rbus_pkg::*;
#(
   parameter logic [7:0] MY_ADDR   = 8'h00,
   parameter int         NUM_BYTES = 4,
   parameter int         DEPTH     = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   wca_read_multi_reg_if.slave          cap,
   output logic [$clog2(DEPTH):0]       level,
   output logic                         overflow,
   input  logic [RBUS_CTRL_W-1:0]       rbusCtrl,
   inout  wire  [RBUS_DATA_W-1:0]       rbusData
);
   localparam int WIDTH = 8 * NUM_BYTES;
   localparam int SEL_W = sel_width(NUM_BYTES);
   localparam int LW    = $clog2(DEPTH) + 1;

   logic [7:0]             bus_addr;
   logic                   bus_rd_en;
   logic                   bus_stb;
   logic                   bus_clk;
   logic                   unused_wr_en;
   logic                   clkbus_q, clkbus_d;
   logic [SEL_W-1:0]       sel_q, sel_d;
   logic                   overflow_q, overflow_d;
   logic                   bus_edge;
   logic                   addr_hit;
   logic                   rd;
   logic                   advance;
   logic                   last_byte;
   logic                   pop;
   logic                   drop;
   logic [WIDTH-1:0]       head_word;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic [LW-1:0]          fifo_level;
   logic [RBUS_DATA_W-1:0] rd_byte;

   assign bus_addr     = rbusCtrl[RBUS_ADDR_MSB:RBUS_ADDR_LSB];
   assign bus_rd_en    = rbusCtrl[RBUS_RD_BIT];
   assign bus_stb      = rbusCtrl[RBUS_STB_BIT];
   assign bus_clk      = rbusCtrl[RBUS_CLK_BIT];
   // The register is read-only; writes to this address are ignored.
   assign unused_wr_en = rbusCtrl[RBUS_WR_BIT];

   assign clkbus_d  = bus_clk;
   assign bus_edge  = bus_clk & ~clkbus_q;
   assign addr_hit  = (bus_addr == MY_ADDR);
   assign rd        = addr_hit & bus_rd_en;
   assign advance   = bus_edge & rd & bus_stb;
   assign last_byte = (sel_q == SEL_W'(NUM_BYTES - 1));
   // The FIFO ignores pop when empty, so empty reads never underflow level.
   assign pop       = advance & last_byte;
   // Full is judged before any same-cycle pop: the capture side has no bus path.
   assign drop      = cap.in_valid & fifo_full;

   assign rd_byte      = head_word[{sel_q, 3'b000} +: 8];
   assign cap.in_ready = ~fifo_full;
   assign level        = fifo_level;
   assign overflow     = overflow_q;

   wca_sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (cap.in_valid),
      .push_data (cap.in),
      .pop       (pop),
      .head      (head_word),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

`ifdef WCA_RDREG_STATUS_EN
   logic [7:0]             stat_addr;
   logic                   rd_stat;
   logic                   stat_clr;
   logic [RBUS_DATA_W-1:0] stat_byte;

   assign stat_addr = MY_ADDR + 8'd1;
   assign rd_stat   = (bus_addr == stat_addr) & bus_rd_en;
   assign stat_clr  = bus_edge & rd_stat & bus_stb;
   assign stat_byte = {overflow_q, 2'b00, 5'(fifo_level)};
   assign rbusData  = rd ? rd_byte : (rd_stat ? stat_byte : 8'bz);
`else
   assign rbusData  = rd ? rd_byte : 8'bz;
`endif

   always_comb begin
      sel_d = sel_q;
      // Leaving the address aborts the word; the head stays for a restart.
      if (!addr_hit) begin
         sel_d = '0;
      end else if (advance) begin
         sel_d = last_byte ? '0 : sel_q + 1'b1;
      end
   end

   always_comb begin
      overflow_d = overflow_q;
`ifdef WCA_RDREG_STATUS_EN
      if (stat_clr) begin
         overflow_d = 1'b0;
      end
`endif
      // A drop in the same cycle as a status clear must stay visible.
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         clkbus_q   <= 1'b0;
         sel_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         clkbus_q   <= clkbus_d;
         sel_q      <= sel_d;
         overflow_q <= overflow_d;
      end
   end

endmodule
